// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage with PC, one-outstanding imem
// request, IF/ID register, one-entry skid buffer and redirect squash.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req/addr/ready     request channel (addr is the PC, word aligned)
//   imem_rvalid/rdata       response channel
//   stall                   decode cannot consume IF/ID this cycle
//   redirect/redirect_pc    load new PC, flush IF/ID and skid
//   id_valid/instr/op       IF/ID contents; id_op = id_instr[31:26]
//   id_pc_plus4             PC of id_instr + 4
// Optional (FETCH_PERF_CNT_EN): perf_fetched, perf_stall_cycles.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [5:0]  id_op,
    output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc_inc;
    logic        accept;
    logic        load;

    // Low address bits of a redirect target are dropped on purpose.
    logic unused_rpc;
    assign unused_rpc = ^redirect_pc[1:0];

    assign pc_inc = pc_q + 32'd4;
    assign accept = !valid_q || !stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        skid_d  = skid_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        load    = 1'b0;
        // Consumed entry drops unless a new word replaces it below.
        if (valid_q && !stall) valid_d = 1'b0;
        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            // An accepted request still owes a response: drain it.
            case (state_q)
                S_REQ:   state_d = imem_ready ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: if (imem_ready) state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = pc_inc;
                        if (accept) begin
                            load    = 1'b1;
                            valid_d = 1'b1;
                            instr_d = imem_rdata;
                            pc4_d   = pc_inc;
                            state_d = S_REQ;
                        end else begin
                            skid_d  = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // PC already advanced past the skid word.
                    if (accept) begin
                        load    = 1'b1;
                        valid_d = 1'b1;
                        instr_d = skid_q;
                        pc4_d   = pc_q;
                        state_d = S_REQ;
                    end
                end
                S_DRAIN: if (imem_rvalid) state_d = S_REQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            skid_q  <= 32'd0;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign id_valid    = valid_q;
    assign id_instr    = instr_q;
    assign id_op       = instr_q[31:26];
    assign id_pc_plus4 = pc4_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= 32'd0;
            stalls_q  <= 32'd0;
        end else begin
            if (load) fetched_q <= fetched_q + 32'd1;
            if (valid_q && stall) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_fetched      = fetched_q;
    assign perf_stall_cycles = stalls_q;
`else
    // No performance counters in this build; load is informational only.
    logic unused_load;
    assign unused_load = load;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit with a scoreboard queue
// of expected IF/ID words checked by a monitor on each decode consume.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready, imem_rvalid, stall, redirect;
    logic [31:0] imem_rdata, redirect_pc;

    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_instr, id_pc_plus4;
    logic [5:0]  id_op;
    logic        u1_req, u1_valid;
    logic [31:0] u1_addr, u1_instr, u1_pc4;
    logic [5:0]  u1_op;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pf0, ps0, pf1, ps1;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit u0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr),
        .id_op(id_op), .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(pf0), .perf_stall_cycles(ps0)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(u1_req), .imem_addr(u1_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(u1_valid), .id_instr(u1_instr),
        .id_op(u1_op), .id_pc_plus4(u1_pc4)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(pf1), .perf_stall_cycles(ps1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
        exp_t e;
        e.instr = instr;
        e.pc4   = pc4;
        sb.push_back(e);
    endtask

    // Monitor: every consumed IF/ID entry must match the queue head.
    always @(negedge clk) begin
        if (rst_n && id_valid && !stall) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_id: got 0x%08h expected none",
                         id_instr);
            end else begin
                exp_t e;
                logic [31:0] w;
                e = sb.pop_front();
                w = e.instr;
                chk("sb_instr", id_instr, w);
                chk("sb_op", {26'd0, id_op}, {26'd0, w[31:26]});
                chk("sb_pc4", id_pc_plus4, e.pc4);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        imem_ready = 0; imem_rvalid = 0; stall = 0; redirect = 0;
        imem_rdata = 0; redirect_pc = 0;
        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            imem_ready  = 1'($urandom);
            imem_rvalid = 1'($urandom);
            stall       = 1'($urandom);
            redirect    = 1'($urandom);
            imem_rdata  = $urandom;
            redirect_pc = $urandom;
            cyc();
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_addr", imem_addr, 32'd0);
            chk("rst_valid", {31'd0, id_valid}, 32'd0);
            chk("rst_instr", id_instr, 32'd0);
            chk("rst_op", {26'd0, id_op}, 32'd0);
            chk("rst_pc4", id_pc_plus4, 32'd0);
        end
        imem_ready = 0; imem_rvalid = 0; stall = 0; redirect = 0;
        imem_rdata = 0; redirect_pc = 0;
        rst_n = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        cyc();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);

        // Sequential fetch, one instruction per two cycles
        imem_ready = 1; cyc();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h2008_0005;
        push(32'h2008_0005, 32'h4);
        cyc();
        imem_rvalid = 0;
        chk("seq_op0", {26'd0, id_op}, 32'h08);
        chk("seq_pc4_0", id_pc_plus4, 32'h4);
        chk("seq_addr1", imem_addr, 32'h4);
        imem_ready = 1; cyc();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0020;
        push(32'h0000_0020, 32'h8);
        cyc();
        imem_rvalid = 0;
        chk("seq_op1", {26'd0, id_op}, 32'h00);
        chk("seq_pc4_1", id_pc_plus4, 32'h8);
        imem_ready = 1; cyc();
        chk("consumed", {31'd0, id_valid}, 32'd0);

        // Stall with a response arriving: skid buffer
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h8C0A_0000;
        stall = 1; push(32'h8C0A_0000, 32'hC);
        cyc();
        imem_rvalid = 0; imem_ready = 1; cyc();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'hAC09_0004;
        push(32'hAC09_0004, 32'h10);
        cyc();
        imem_rvalid = 0;
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_instr", id_instr, 32'h8C0A_0000);
        chk("hold_valid", {31'd0, id_valid}, 32'd1);
        chk("hold_addr", imem_addr, 32'h10);
        cyc();
        chk("hold_req2", {31'd0, imem_req}, 32'd0);
        stall = 0; cyc();
        stall = 1;
        chk("skid_instr", id_instr, 32'hAC09_0004);
        chk("skid_pc4", id_pc_plus4, 32'h10);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h10);

        // Redirect in WAIT without response -> DRAIN
        imem_ready = 1; cyc();
        imem_ready = 0; redirect = 1; redirect_pc = 32'h0000_0103;
        void'(sb.pop_front());
        cyc();
        redirect = 0; stall = 0;
        chk("rd_valid", {31'd0, id_valid}, 32'd0);
        chk("rd_req", {31'd0, imem_req}, 32'd0);
        chk("rd_addr", imem_addr, 32'h100);
        cyc();
        chk("drain_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; cyc();
        imem_rvalid = 0;
        chk("drain_valid", {31'd0, id_valid}, 32'd0);
        chk("drain_req2", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h100);

        // Redirect same cycle as rvalid in WAIT -> REQ directly
        imem_ready = 1; cyc();
        imem_ready = 0; redirect = 1; redirect_pc = 32'h180;
        imem_rvalid = 1; imem_rdata = 32'h1111_1111;
        cyc();
        redirect = 0; imem_rvalid = 0;
        chk("rdv_req", {31'd0, imem_req}, 32'd1);
        chk("rdv_addr", imem_addr, 32'h180);
        chk("rdv_valid", {31'd0, id_valid}, 32'd0);

        // Into DRAIN, then redirect again while draining
        imem_ready = 1; cyc();
        imem_ready = 0; redirect = 1; redirect_pc = 32'h1C0; cyc();
        chk("dd_req", {31'd0, imem_req}, 32'd0);
        redirect_pc = 32'h200; cyc();
        redirect = 0;
        chk("dd_req2", {31'd0, imem_req}, 32'd0);
        chk("dd_addr", imem_addr, 32'h200);
        imem_rvalid = 1; imem_rdata = 32'h2222_2222; cyc();
        imem_rvalid = 0;
        chk("dd_req3", {31'd0, imem_req}, 32'd1);
        chk("dd_addr2", imem_addr, 32'h200);
        chk("dd_valid", {31'd0, id_valid}, 32'd0);
        imem_ready = 1; cyc();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h3C01_ABCD;
        push(32'h3C01_ABCD, 32'h204);
        cyc();
        imem_rvalid = 0;
        chk("tgt_op", {26'd0, id_op}, 32'h0F);

        // Redirect in REQ with handshake same cycle -> DRAIN
        imem_ready = 1; redirect = 1; redirect_pc = 32'h300; cyc();
        imem_ready = 0; redirect = 0;
        chk("rr_req", {31'd0, imem_req}, 32'd0);
        chk("rr_addr", imem_addr, 32'h300);
        imem_rvalid = 1; imem_rdata = 32'h3333_3333; cyc();
        imem_rvalid = 0;
        chk("rr_req2", {31'd0, imem_req}, 32'd1);
        chk("rr_valid", {31'd0, id_valid}, 32'd0);

        // PC wrap on u1 and performance counters
        rst_n = 0; cyc();
        chk("w_rst_addr", u1_addr, 32'hFFFF_FFFC);
        chk("w_rst_pc4", u1_pc4, 32'd0);
        rst_n = 1;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_rst_f", pf1, 32'd0);
        chk("perf_rst_s", ps1, 32'd0);
`endif
        cyc();
        chk("w_req", {31'd0, u1_req}, 32'd1);
        chk("w_addr", u1_addr, 32'hFFFF_FFFC);
        imem_ready = 1; cyc();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h2008_0005;
        push(32'h2008_0005, 32'h4);
        cyc();
        imem_rvalid = 0;
        chk("w_pc4", u1_pc4, 32'h0);
        chk("w_next_addr", u1_addr, 32'h0);
        chk("w_op", {26'd0, u1_op}, 32'h08);
        imem_ready = 1; cyc();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0020;
        stall = 1; push(32'h0000_0020, 32'h8);
        cyc();
        imem_rvalid = 0; imem_ready = 1; cyc();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h8C0A_0000;
        push(32'h8C0A_0000, 32'hC);
        cyc();
        imem_rvalid = 0;
        cyc();
        cyc();
        stall = 0; cyc();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", pf1, 32'd3);
        chk("perf_stalls", ps1, 32'd4);
        chk("perf_fetched0", pf0, 32'd3);
`endif
        chk("w_u1_instr", u1_instr, 32'h8C0A_0000);
        cyc();
        cyc();
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
